// File: rtl/eh2_dec_trigger_hit_ctl.sv
// Per-thread trigger hit sequencer: qualifies decode trigger matches, latches sticky mhit,
// handshakes with TLU and blocks decode until flush. Optional chain rule: RV_TRIGGER_CHAIN_EN.
module eh2_dec_trigger_hit_ctl #(
  parameter  int NUM_THREADS = 2,
  parameter  int NUM_TRIG    = 4,
  localparam int TW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_i0_valid_d,
  input  logic                                  i_i1_valid_d,
  input  logic [TW-1:0]                         i_i0_tid,
  input  logic [TW-1:0]                         i_i1_tid,
  input  logic [NUM_TRIG-1:0]                   i_i0_match_d,
  input  logic [NUM_TRIG-1:0]                   i_i1_match_d,
  input  logic [NUM_THREADS-1:0][NUM_TRIG-1:0]  i_trig_action,
  input  logic [NUM_THREADS-1:0][NUM_TRIG-1:0]  i_trig_chain,
  input  logic [NUM_THREADS-1:0]                i_tlu_flush,
  input  logic [NUM_THREADS-1:0]                i_tlu_hit_ack,
  input  logic [NUM_THREADS-1:0][NUM_TRIG-1:0]  i_mhit_clr,
  output logic [NUM_THREADS-1:0]                o_hit_req,
  output logic [NUM_THREADS-1:0]                o_hit_action,
  output logic [NUM_THREADS-1:0]                o_hit_slot,
  output logic [NUM_THREADS-1:0][NUM_TRIG-1:0]  o_mhit,
  output logic                                  o_i1_trig_kill,
  output logic [NUM_THREADS-1:0]                o_dec_trig_block,
  output logic [NUM_THREADS-1:0][1:0]           o_dbg_state
);

  // Handshake: o_hit_req is a level held in REQ until the cycle i_tlu_hit_ack is seen;
  // hit_action/hit_slot are meaningful only while o_hit_req is high.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_BLOCK = 2'd2
  } state_t;

  logic [NUM_THREADS-1:0] w_kill;

`ifdef RV_TRIGGER_CHAIN_EN
  // A chained pair only counts when both members matched on the same instruction.
  function automatic logic [NUM_TRIG-1:0] f_chain(input logic [NUM_TRIG-1:0] q,
                                                  input logic [NUM_TRIG-1:0] ch);
    logic [NUM_TRIG-1:0] r;
    r = q;
    if (ch[0] && !(q[0] && q[1])) r[1:0] = 2'b00;
    if (ch[2] && !(q[2] && q[3])) r[3:2] = 2'b00;
    return r;
  endfunction
`else
  logic w_unused_chain;
  assign w_unused_chain = ^i_trig_chain;
`endif

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
    logic [NUM_TRIG-1:0] w_q0_raw, w_q1_raw, w_q0, w_q1, w_cap_vec;
    logic                w_hit0, w_hit1, w_cap_en;
    state_t              r_state;
    logic                r_hit_req, r_action, r_slot, r_block;
    logic [NUM_TRIG-1:0] r_mhit;

    assign w_q0_raw = i_i0_match_d & {NUM_TRIG{i_i0_valid_d && (i_i0_tid == TW'(t))}};
    assign w_q1_raw = i_i1_match_d & {NUM_TRIG{i_i1_valid_d && (i_i1_tid == TW'(t))}};
`ifdef RV_TRIGGER_CHAIN_EN
    assign w_q0 = f_chain(w_q0_raw, i_trig_chain[t]);
    assign w_q1 = f_chain(w_q1_raw, i_trig_chain[t]);
`else
    assign w_q0 = w_q0_raw;
    assign w_q1 = w_q1_raw;
`endif
    assign w_hit0 = |w_q0;
    assign w_hit1 = |w_q1;

    // Only an idle thread not being flushed accepts a new hit; i0 is older so it wins.
    assign w_cap_en  = (r_state == S_IDLE) && !i_tlu_flush[t] && (w_hit0 || w_hit1);
    assign w_cap_vec = !w_cap_en ? '0 : (w_hit0 ? w_q0 : w_q1);
    assign w_kill[t] = w_cap_en && w_hit0 && i_i1_valid_d && (i_i1_tid == TW'(t));

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_state   <= S_IDLE;
        r_hit_req <= 1'b0;
        r_action  <= 1'b0;
        r_slot    <= 1'b0;
        r_block   <= 1'b0;
        r_mhit    <= '0;
      end else begin
        // Capture set has priority over the write-1-to-clear on the same bit.
        r_mhit <= (r_mhit & ~i_mhit_clr[t]) | w_cap_vec;
        case (r_state)
          S_IDLE: begin
            if (w_cap_en) begin
              r_state   <= S_REQ;
              r_hit_req <= 1'b1;
              r_block   <= 1'b1;
              r_action  <= |(w_cap_vec & i_trig_action[t]);
              r_slot    <= !w_hit0;
            end
          end
          S_REQ: begin
            if (i_tlu_flush[t]) begin
              r_state   <= S_IDLE;
              r_hit_req <= 1'b0;
              r_block   <= 1'b0;
              r_action  <= 1'b0;
              r_slot    <= 1'b0;
            end else if (i_tlu_hit_ack[t]) begin
              r_state   <= S_BLOCK;
              r_hit_req <= 1'b0;
              r_action  <= 1'b0;
              r_slot    <= 1'b0;
            end
          end
          S_BLOCK: begin
            if (i_tlu_flush[t]) begin
              r_state <= S_IDLE;
              r_block <= 1'b0;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_hit_req <= 1'b0;
            r_block   <= 1'b0;
            r_action  <= 1'b0;
            r_slot    <= 1'b0;
          end
        endcase
      end
    end

    assign o_hit_req[t]        = r_hit_req;
    assign o_hit_action[t]     = r_action;
    assign o_hit_slot[t]       = r_slot;
    assign o_dec_trig_block[t] = r_block;
    assign o_mhit[t]           = r_mhit;
    assign o_dbg_state[t]      = r_state;
  end

  assign o_i1_trig_kill = |w_kill;

endmodule

// File: tb/tb_eh2_dec_trigger_hit_ctl.sv
// Directed bench for eh2_dec_trigger_hit_ctl; expected outputs are queued with each step.
module tb_eh2_dec_trigger_hit_ctl;
  localparam int NT = 2;
  localparam int TW = 1;

  logic                clk, rst;
  logic                i0_valid, i1_valid;
  logic [TW-1:0]       i0_tid, i1_tid;
  logic [3:0]          i0_match, i1_match;
  logic [NT-1:0][3:0]  trig_action, trig_chain, mhit_clr;
  logic [NT-1:0]       flush, ack;
  logic [NT-1:0]       hit_req, hit_action, hit_slot, blk;
  logic [NT-1:0][3:0]  mhit;
  logic                kill;
  logic [NT-1:0][1:0]  dbg_state;

  logic [15:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  eh2_dec_trigger_hit_ctl #(.NUM_THREADS(NT), .NUM_TRIG(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_i0_valid_d(i0_valid), .i_i1_valid_d(i1_valid),
    .i_i0_tid(i0_tid), .i_i1_tid(i1_tid),
    .i_i0_match_d(i0_match), .i_i1_match_d(i1_match),
    .i_trig_action(trig_action), .i_trig_chain(trig_chain),
    .i_tlu_flush(flush), .i_tlu_hit_ack(ack), .i_mhit_clr(mhit_clr),
    .o_hit_req(hit_req), .o_hit_action(hit_action), .o_hit_slot(hit_slot),
    .o_mhit(mhit), .o_i1_trig_kill(kill), .o_dec_trig_block(blk),
    .o_dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed layout: {req[1:0], action[1:0], slot[1:0], mhit[1], mhit[0], block[1:0]}
  function automatic logic [15:0] obs_vec();
    return {hit_req, hit_action, hit_slot, mhit, blk};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic set_idle();
    i0_valid = 1'b0; i1_valid = 1'b0;
    i0_tid   = '0;   i1_tid   = '0;
    i0_match = '0;   i1_match = '0;
    flush    = '0;   ack      = '0;
    mhit_clr = '0;
  endtask

  task automatic check_kill(input string tag, input logic exp_k);
    #1;
    check(tag, {15'b0, kill}, {15'b0, exp_k});
  endtask

  // Push the outputs expected after the coming edge, then compare once they appear.
  task automatic step(input string tag, input logic [1:0] req, input logic [1:0] act,
                      input logic [1:0] slot, input logic [7:0] mh, input logic [1:0] b);
    logic [15:0] e;
    exp_q.push_back({req, act, slot, mh, b});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check(tag, obs_vec(), e);
    set_idle();
  endtask

  task automatic drive_i0(input logic [TW-1:0] tid, input logic [3:0] m);
    i0_valid = 1'b1; i0_tid = tid; i0_match = m;
  endtask

  task automatic drive_i1(input logic [TW-1:0] tid, input logic [3:0] m);
    i1_valid = 1'b1; i1_tid = tid; i1_match = m;
  endtask

  initial begin
    int          b;
    logic [3:0]  m;
    set_idle();
    trig_action = '0;
    trig_chain  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", obs_vec(), 16'h0);
    check("reset_kill", {15'b0, kill}, 16'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic hit, ack, flush on T0
    drive_i0(0, 4'b0001);
    check_kill("t1_kill", 1'b0);
    step("t1_hit", 2'b01, 2'b00, 2'b00, 8'h01, 2'b01);
    ack[0] = 1'b1;
    step("t1_ack", 2'b00, 2'b00, 2'b00, 8'h01, 2'b01);
    check("t1_state_block", {14'b0, dbg_state[0]}, 16'd2);
    ack[0] = 1'b1;
    step("t1_ack_in_block", 2'b00, 2'b00, 2'b00, 8'h01, 2'b01);
    flush[0] = 1'b1;
    step("t1_flush", 2'b00, 2'b00, 2'b00, 8'h01, 2'b00);
    mhit_clr[0] = 4'hf;
    step("t1_clr", 2'b00, 2'b00, 2'b00, 8'h00, 2'b00);

    // i0 and i1 on the same thread: i0 wins, i1 killed
    drive_i0(0, 4'b0010);
    drive_i1(0, 4'b1000);
    check_kill("t2_kill", 1'b1);
    step("t2_hit", 2'b01, 2'b00, 2'b00, 8'h02, 2'b01);

    // New hit while in REQ is dropped without kill
    drive_i0(0, 4'b0100);
    drive_i1(0, 4'b1000);
    check_kill("t5_drop_kill", 1'b0);
    step("t5_drop", 2'b01, 2'b00, 2'b00, 8'h02, 2'b01);
    flush[0] = 1'b1; ack[0] = 1'b1;
    step("t5_flush_ack", 2'b00, 2'b00, 2'b00, 8'h02, 2'b00);
    check("t5_state_idle", {14'b0, dbg_state[0]}, 16'd0);
    mhit_clr[0] = 4'hf;
    step("t5_clr", 2'b00, 2'b00, 2'b00, 8'h00, 2'b00);

    // Flush and new hit in the same cycle: hit dropped
    drive_i0(0, 4'b0100);
    drive_i1(0, 4'b0001);
    flush[0] = 1'b1;
    check_kill("flush_hit_kill", 1'b0);
    step("flush_hit_drop", 2'b00, 2'b00, 2'b00, 8'h00, 2'b00);

    // i1 hit on T1 with debug action, T0 untouched
    trig_action[1] = 4'b0100;
    drive_i0(0, 4'b0000);
    drive_i1(1, 4'b0100);
    check_kill("t3_kill", 1'b0);
    step("t3_hit", 2'b10, 2'b10, 2'b10, 8'h40, 2'b10);
    ack[1] = 1'b1;
    step("t3_ack", 2'b00, 2'b00, 2'b00, 8'h40, 2'b10);
    flush[1] = 1'b1;
    step("t3_flush", 2'b00, 2'b00, 2'b00, 8'h40, 2'b00);
    mhit_clr[1] = 4'hf;
    step("t3_clr", 2'b00, 2'b00, 2'b00, 8'h00, 2'b00);

    // Independent hits on both threads in one cycle
    trig_action[0] = 4'b0001;
    drive_i0(0, 4'b0001);
    drive_i1(1, 4'b1000);
    check_kill("indep_kill", 1'b0);
    step("indep_hit", 2'b11, 2'b01, 2'b10, 8'h81, 2'b11);
    flush = 2'b11;
    step("indep_flush", 2'b00, 2'b00, 2'b00, 8'h81, 2'b00);
    mhit_clr = '1;
    step("indep_clr", 2'b00, 2'b00, 2'b00, 8'h00, 2'b00);
    trig_action = '0;

    // Capture set wins over clear on the same bit
    drive_i0(0, 4'b0001);
    step("t6_hit", 2'b01, 2'b00, 2'b00, 8'h01, 2'b01);
    flush[0] = 1'b1;
    step("t6_flush", 2'b00, 2'b00, 2'b00, 8'h01, 2'b00);
    drive_i0(0, 4'b0001);
    mhit_clr[0] = 4'b0001;
    step("t6_set_over_clr", 2'b01, 2'b00, 2'b00, 8'h01, 2'b01);
    flush[0] = 1'b1;
    step("t6_flush2", 2'b00, 2'b00, 2'b00, 8'h01, 2'b00);
    mhit_clr[0] = 4'b0001;
    step("t6_clr_alone", 2'b00, 2'b00, 2'b00, 8'h00, 2'b00);

    // Chain pair 0/1 on T0
    trig_chain[0] = 4'b0001;
    drive_i0(0, 4'b0001);
`ifdef RV_TRIGGER_CHAIN_EN
    step("t4_chain_half", 2'b00, 2'b00, 2'b00, 8'h00, 2'b00);
    drive_i0(0, 4'b0011);
    step("t4_chain_full", 2'b01, 2'b00, 2'b00, 8'h03, 2'b01);
`else
    step("t4_nochain", 2'b01, 2'b00, 2'b00, 8'h01, 2'b01);
`endif
    flush[0] = 1'b1;
    mhit_clr[0] = 4'hf;
    step("t4_flush_clr", 2'b00, 2'b00, 2'b00, 8'h00, 2'b00);
    trig_chain = '0;

    // Random single trigger on T1 via i1, then async reset mid-handshake
    b = $urandom_range(0, 3);
    m = 4'(1 << b);
    drive_i1(1, m);
    step("rand_i1_hit", 2'b10, 2'b00, 2'b10, {m, 4'h0}, 2'b10);
    #2 rst = 1'b1;
    #1;
    check("async_reset", obs_vec(), 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    step("post_reset_idle", 2'b00, 2'b00, 2'b00, 8'h00, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
